// File: rtl/sram_resp_confreg_pkg.sv
// Shared constants, config-register decode and byte-lane merge helper for the
// SRAM-response / config-register block.
package sram_resp_confreg_pkg;

  localparam logic [15:0] CONF_HI_DEF   = 16'hBFAF;
  localparam logic [15:0] OFF_CR_BASE   = 16'h8000;
  localparam logic [15:0] OFF_TIMER     = 16'hE000;
  localparam logic [15:0] OFF_LED       = 16'hF020;
  localparam logic [15:0] OFF_SWITCH    = 16'hF030;
  localparam logic [15:0] OFF_NUM       = 16'hF050;
  localparam logic [3:0]  TIMER_WE_FULL = 4'hF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CR,
    REG_TIMER,
    REG_LED,
    REG_SWITCH,
    REG_NUM
  } conf_reg_e;

  // Word offset (addr[15:2]) to register kind; CR0-CR7 share one 8-word window.
  function automatic conf_reg_e decode_off(input logic [13:0] woff);
    if (woff[13:3] == OFF_CR_BASE[15:5])   return REG_CR;
    else if (woff == OFF_TIMER[15:2])      return REG_TIMER;
    else if (woff == OFF_LED[15:2])        return REG_LED;
    else if (woff == OFF_SWITCH[15:2])     return REG_SWITCH;
    else if (woff == OFF_NUM[15:2])        return REG_NUM;
    else                                   return REG_NONE;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_confreg_if.sv
// CPU data-port SRAM-style bus: strobe, byte enables, address, data.
interface sram_resp_confreg_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (output sram_en, sram_we, sram_addr, sram_wdata, input sram_rdata);
  modport slave  (input sram_en, sram_we, sram_addr, sram_wdata, output sram_rdata);
endinterface

// File: rtl/sram_resp_ram.sv
// Single-port byte-enabled RAM, read-first, with a registered (resettable) output.
module sram_resp_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset so it can map onto a RAM macro; only the
  // output register is reset, which is what keeps rdata at 0 during reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // NOTE: non-blocking reads the pre-edge word, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_resp_confreg.sv
// RAM plus memory-mapped config registers (CR0-7, TIMER, LED, SWITCH, NUM)
// behind one SRAM-style port with 1-cycle registered read data.
module sram_resp_confreg
  import sram_resp_confreg_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] CONF_HI = CONF_HI_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_resp_confreg_if.slave   bus,
  input  logic [7:0]           switch_in,
  output logic [15:0]          led_out,
  output logic [31:0]          num_out
);

  logic        conf_sel, conf_acc, conf_wr, ram_en;
  conf_reg_e   reg_sel;
  logic [2:0]  cr_idx;
  logic [31:0] ram_rdata, conf_rd, led_w;

  logic [31:0] cr_q [8];
  logic [31:0] cr_d [8];
  logic [31:0] timer_q, timer_d, num_q, num_d, conf_rdata_q;
  logic [15:0] led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic        sel_q;

  assign conf_sel = (bus.sram_addr[31:16] == CONF_HI);
  assign conf_acc = bus.sram_en & conf_sel;
  assign conf_wr  = conf_acc & (|bus.sram_we);
  assign ram_en   = bus.sram_en & ~conf_sel;
  assign reg_sel  = decode_off(bus.sram_addr[15:2]);
  assign cr_idx   = bus.sram_addr[4:2];

  sram_resp_ram #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .rst_n   (resetn),
    .en_i    (ram_en),
    .we_i    (bus.sram_we),
    .addr_i  (bus.sram_addr[RAM_AW+1:2]),
    .wdata_i (bus.sram_wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    cr_d    = cr_q;
    timer_d = timer_q + 32'd1;
    led_d   = led_q;
    num_d   = num_q;
    led_w   = merge_lanes({16'h0, led_q}, bus.sram_wdata, bus.sram_we);
    conf_rd = '0;

    case (reg_sel)
      REG_CR:     conf_rd = cr_q[cr_idx];
      REG_TIMER:  conf_rd = timer_q;
      REG_LED:    conf_rd = {16'h0, led_q};
      REG_SWITCH: conf_rd = {24'h0, sw_sync_q};
      REG_NUM:    conf_rd = num_q;
      default:    conf_rd = '0;
    endcase

    if (conf_wr) begin
      case (reg_sel)
        REG_CR:    cr_d[cr_idx] = merge_lanes(cr_q[cr_idx], bus.sram_wdata, bus.sram_we);
        REG_TIMER: if (bus.sram_we == TIMER_WE_FULL) timer_d = bus.sram_wdata;
        REG_LED:   led_d = led_w[15:0];
        REG_NUM:   num_d = merge_lanes(num_q, bus.sram_wdata, bus.sram_we);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) cr_q[i] <= '0;
      timer_q      <= '0;
      led_q        <= '0;
      num_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      conf_rdata_q <= '0;
      sel_q        <= 1'b0;
    end else begin
      cr_q      <= cr_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      num_q     <= num_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      if (conf_acc)    conf_rdata_q <= conf_rd;
      if (bus.sram_en) sel_q        <= conf_sel;
    end
  end

  // Source select is registered with the access so idle cycles hold rdata.
  assign bus.sram_rdata = sel_q ? conf_rdata_q : ram_rdata;
  assign led_out        = led_q;
  assign num_out        = num_q;

endmodule

// File: tb/tb_sram_resp_confreg.sv
// Scoreboard bench: a behavioural model predicts each access's read data,
// queues it at drive time and compares it one edge later.
module tb_sram_resp_confreg;

  localparam logic [15:0] TB_CONF_HI = 16'hBFAF;

  logic        clk;
  logic        resetn;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  sram_resp_confreg_if bus_if ();

  sram_resp_confreg dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [31:0] m_mem [int];
  logic [31:0] m_cr [8];
  logic [31:0] m_timer, m_num;
  logic [15:0] m_led;
  logic [7:0]  m_s1, m_s2;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cr[i] = '0;
    m_timer = '0; m_num = '0; m_led = '0; m_s1 = '0; m_s2 = '0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [15:0] off;
    int          idx;
    off = {a[15:2], 2'b00};
    idx = int'(a[15:2]);
    if (a[31:16] != TB_CONF_HI) return m_mem.exists(idx) ? m_mem[idx] : 32'h0;
    if (off >= 16'h8000 && off <= 16'h801C) return m_cr[off[4:2]];
    case (off)
      16'hE000: return m_timer;
      16'hF020: return {16'h0, m_led};
      16'hF030: return {24'h0, m_s2};
      16'hF050: return m_num;
      default:  return 32'h0;
    endcase
  endfunction

  // One bus cycle: predict, update model, clock, then compare away from the edge.
  task automatic cycle(input logic en, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [15:0] off;
    logic [31:0] lw;
    bit          pushed;
    int          idx;
    bus_if.sram_en    = en;
    bus_if.sram_we    = we;
    bus_if.sram_addr  = a;
    bus_if.sram_wdata = wd;
    pushed = 0;
    off = {a[15:2], 2'b00};
    idx = int'(a[15:2]);
    if (en) begin
      exp_q.push_back(model_read(a));
      pushed = 1;
    end
    if (en && we == 4'hF && a[31:16] == TB_CONF_HI && off == 16'hE000) m_timer = wd;
    else m_timer = m_timer + 32'd1;
    m_s2 = m_s1;
    m_s1 = switch_in;
    if (en && we != 4'h0) begin
      if (a[31:16] != TB_CONF_HI) begin
        m_mem[idx] = lanes(m_mem.exists(idx) ? m_mem[idx] : 32'h0, wd, we);
      end else if (off >= 16'h8000 && off <= 16'h801C) begin
        m_cr[off[4:2]] = lanes(m_cr[off[4:2]], wd, we);
      end else if (off == 16'hF020) begin
        lw = lanes({16'h0, m_led}, wd, we);
        m_led = lw[15:0];
      end else if (off == 16'hF050) begin
        m_num = lanes(m_num, wd, we);
      end
    end
    @(posedge clk);
    #1;
    if (pushed) check("rdata", bus_if.sram_rdata, exp_q.pop_front());
    check("led_out", {16'h0, led_out}, {16'h0, m_led});
    check("num_out", num_out, m_num);
  endtask

  localparam logic [31:0] A_RAM    = 32'h0000_0010;
  localparam logic [31:0] A_TIMER  = 32'hBFAF_E000;
  localparam logic [31:0] A_LED    = 32'hBFAF_F020;
  localparam logic [31:0] A_SWITCH = 32'hBFAF_F030;
  localparam logic [31:0] A_NUM    = 32'hBFAF_F050;

  logic [31:0] held;

  initial begin
    resetn = 1'b0;
    switch_in = 8'h00;
    bus_if.sram_en = 1'b0; bus_if.sram_we = 4'h0;
    bus_if.sram_addr = '0; bus_if.sram_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus_if.sram_rdata, 32'h0);
    check("rst_led", {16'h0, led_out}, 32'h0);
    check("rst_num", num_out, 32'h0);
    resetn = 1'b1;

    // RAM full write, partial write, read-first
    cycle(1, 4'hF, A_RAM, 32'h1122_3344);
    cycle(1, 4'h0, A_RAM, 32'h0);
    check("ram_full", bus_if.sram_rdata, 32'h1122_3344);
    cycle(1, 4'b0010, A_RAM, 32'hAABB_CCDD);
    cycle(1, 4'h0, A_RAM, 32'h0);
    check("ram_lane1", bus_if.sram_rdata, 32'h1122_CC44);
    cycle(1, 4'hF, A_RAM, 32'h0);
    check("ram_rdfirst", bus_if.sram_rdata, 32'h1122_CC44);
    cycle(1, 4'h0, A_RAM, 32'h0);
    check("ram_after", bus_if.sram_rdata, 32'h0);

    // Upper-bit aliasing onto word 5 and hold with sram_en=0
    cycle(1, 4'hF, 32'h0001_0014, 32'hDEAD_BEEF);
    cycle(1, 4'h0, 32'h0000_0014, 32'h0);
    check("ram_alias", bus_if.sram_rdata, 32'hDEAD_BEEF);
    held = bus_if.sram_rdata;
    cycle(0, 4'h0, 32'h0000_0010, 32'h0);
    cycle(0, 4'hF, A_LED, 32'h0);
    check("hold_idle", bus_if.sram_rdata, held);

    // TIMER load, wrap, ignored partial write
    cycle(1, 4'hF, A_TIMER, 32'hFFFF_FFFE);
    cycle(0, 4'h0, 32'h0, 32'h0);
    cycle(1, 4'h0, A_TIMER, 32'h0);
    check("timer_ff", bus_if.sram_rdata, 32'hFFFF_FFFF);
    cycle(1, 4'h0, A_TIMER, 32'h0);
    check("timer_wrap", bus_if.sram_rdata, 32'h0000_0000);
    cycle(1, 4'b0001, A_TIMER, 32'h0000_0077);
    cycle(1, 4'h0, A_TIMER, 32'h0);
    check("timer_part", bus_if.sram_rdata, 32'h0000_0002);

    // LED, NUM lanes
    cycle(1, 4'hF, A_LED, 32'hFFFF_5A5A);
    check("led_val", {16'h0, led_out}, 32'h0000_5A5A);
    cycle(1, 4'h0, A_LED, 32'h0);
    check("led_rd", bus_if.sram_rdata, 32'h0000_5A5A);
    cycle(1, 4'hF, A_NUM, 32'h1234_5678);
    cycle(1, 4'b1000, A_NUM, 32'hFF00_0000);
    check("num_lane3", num_out, 32'hFF34_5678);
    cycle(1, 4'h0, A_NUM, 32'h0);

    // Scratch registers
    cycle(1, 4'hF, 32'hBFAF_800C, 32'hA5A5_A5A5);
    cycle(1, 4'b0101, 32'hBFAF_801C, 32'h1234_5678);
    cycle(1, 4'h0, 32'hBFAF_800C, 32'h0);
    cycle(1, 4'h0, 32'hBFAF_801C, 32'h0);
    check("cr7_lanes", bus_if.sram_rdata, 32'h0034_0078);
    cycle(1, 4'h0, 32'hBFAF_8000, 32'h0);

    // Switch synchronizer latency
    switch_in = 8'hA5;
    cycle(0, 4'h0, 32'h0, 32'h0);
    cycle(0, 4'h0, 32'h0, 32'h0);
    cycle(1, 4'h0, A_SWITCH, 32'h0);
    check("switch", bus_if.sram_rdata, 32'h0000_00A5);

    // Unmapped offset
    cycle(1, 4'hF, 32'hBFAF_F100, 32'hFFFF_FFFF);
    cycle(1, 4'h0, 32'hBFAF_F100, 32'h0);
    check("unmapped", bus_if.sram_rdata, 32'h0);

    // Reset mid-read: pending data discarded, RAM retained
    cycle(1, 4'hF, A_RAM, 32'hCAFE_F00D);
    bus_if.sram_en = 1'b1; bus_if.sram_we = 4'h0;
    bus_if.sram_addr = A_RAM; bus_if.sram_wdata = 32'h0;
    #3;
    resetn = 1'b0;
    #1;
    check("mid_rst_rdata", bus_if.sram_rdata, 32'h0);
    check("mid_rst_led", {16'h0, led_out}, 32'h0);
    check("mid_rst_num", num_out, 32'h0);
    check("mid_rst_timer", dut.timer_q, 32'h0);
    bus_if.sram_en = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_rdata", bus_if.sram_rdata, 32'h0);
    resetn = 1'b1;
    model_reset();
    m_s1 = switch_in;
    m_s2 = 8'h00;
    // First synchronizer stage captures switch_in on the edge after release.
    m_s1 = 8'h00;
    cycle(1, 4'h0, A_RAM, 32'h0);
    check("ram_retained", bus_if.sram_rdata, 32'hCAFE_F00D);
    cycle(1, 4'h0, A_TIMER, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
